// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch defaults, fetch FSM states and
// the {pc, inst} record passed between fetch and its skid buffer.
package riscv_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    // Also decoded by the hazard unit's debug view, so keep the order stable.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RESP  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding register that parks a fetched word while
// decode is stalled, so the memory response is never lost.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  fetch_entry_t load_entry,
    output logic         full,
    output fetch_entry_t entry
);

    logic         full_q;
    logic         full_d;
    fetch_entry_t entry_q;
    fetch_entry_t entry_d;

    // Clear (redirect) beats everything; a load and an unload never coincide.
    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (clear || unload) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            entry_d = load_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign full  = full_q;
    assign entry = entry_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request in
// flight to instruction memory and hands {pc, inst, valid} to decode.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    output logic        icache_re,
    output logic [31:0] icache_addr,
    input  logic        icache_stall,
    input  logic [31:0] icache_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_in,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;

    logic         slot_free;
    logic         in_flight;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_clear;
    logic         skid_full;
    fetch_entry_t skid_in;
    fetch_entry_t skid_out;

    assign slot_free = !if_valid_q || !stall_in;
    assign skid_in   = '{pc: pend_pc_q, inst: icache_dout};

    // A response is still owed to us after this cycle if RESP is waiting or
    // just re-issued, ISSUE got accepted, or FLUSH has not seen its data yet.
    assign in_flight = (state_q == RESP)
                    || (state_q == ISSUE && !icache_stall)
                    || (state_q == FLUSH && icache_stall);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pend_pc_d   = pend_pc_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        icache_re   = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (slot_free) begin
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
        end

        case (state_q)
            IDLE: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                icache_re = 1'b1;
                if (!icache_stall) begin
                    pend_pc_d  = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (!icache_stall) begin
                    if (slot_free) begin
                        // Deliver and re-issue in the same cycle for 1 IPC.
                        if_valid_d = 1'b1;
                        if_pc_d    = pend_pc_q;
                        if_inst_d  = icache_dout;
                        icache_re  = 1'b1;
                        pend_pc_d  = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!skid_full) begin
                    state_d = ISSUE;
                end else if (!stall_in) begin
                    skid_unload = 1'b1;
                    if_valid_d  = 1'b1;
                    if_pc_d     = skid_out.pc;
                    if_inst_d   = skid_out.inst;
                    state_d     = ISSUE;
                end
            end
            FLUSH: begin
                if (!icache_stall) begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_valid && state_q != IDLE) begin
            fetch_pc_d  = redirect_pc & ~32'd3;
            if_valid_d  = 1'b0;
            if_inst_d   = NOP_INST;
            skid_load   = 1'b0;
            skid_clear  = 1'b1;
            state_d     = in_flight ? FLUSH : ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= NOP_INST;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_entry (skid_in),
        .full       (skid_full),
        .entry      (skid_out)
    );

    assign icache_addr = fetch_pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_inst     = if_inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal
// expectations plus a randomized run against an in-order delivery model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        icache_stall = 1'b0;
    logic [31:0] icache_dout;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall_in = 1'b0;
    logic        icache_re;
    logic [31:0] icache_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;
    int deliveries = 0;

    inst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .icache_re      (icache_re),
        .icache_addr    (icache_addr),
        .icache_stall   (icache_stall),
        .icache_dout    (icache_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_in       (stall_in),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    always #5 clk = ~clk;

    // Memory contents: an odd-multiplier hash, so every address holds a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ist, input logic sin,
                                 input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset          = rst;
        icache_stall   = ist;
        stall_in       = sin;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Instruction memory: one outstanding request, data returned on the
    // first later cycle without stall; junk on the bus otherwise.
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] junk = 32'hDEAD_BEEF;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            mem_busy <= 1'b0;
        end else if (icache_re && !icache_stall) begin
            mem_busy <= 1'b1;
            mem_addr <= icache_addr;
        end else if (mem_busy && !icache_stall) begin
            mem_busy <= 1'b0;
        end
        junk <= $urandom;
    end

    always_comb icache_dout = (mem_busy && !icache_stall) ? mem_word(mem_addr) : junk;

    // Delivery model: decode must see PCs in program order, each exactly once,
    // restarting at RESET_PC after reset and at the aligned target after a redirect.
    initial begin : monitor
        logic [31:0] exp_pc;
        logic        live, prev_reset, prev_valid, prev_stall_in, prev_redirect;
        logic [31:0] prev_pc, prev_inst, prev_rpc;
        exp_pc = RESET_PC;
        live = 1'b0; prev_reset = 1'b0; prev_valid = 1'b0;
        prev_stall_in = 1'b0; prev_redirect = 1'b0;
        prev_pc = 32'd0; prev_inst = 32'd0; prev_rpc = 32'd0;
        forever begin
            @(negedge clk);
            if (live) begin
                if (prev_reset) begin
                    checkOutput("mon_reset_valid", 32'(if_valid), 32'd0);
                    checkOutput("mon_reset_pc", if_pc, 32'd0);
                    checkOutput("mon_reset_inst", if_inst, NOP);
                    exp_pc = RESET_PC;
                end else if (prev_redirect) begin
                    checkOutput("mon_redirect_valid", 32'(if_valid), 32'd0);
                    checkOutput("mon_redirect_inst", if_inst, NOP);
                    exp_pc = prev_rpc & 32'hFFFF_FFFC;
                end else if (prev_valid && prev_stall_in) begin
                    checkOutput("mon_hold_valid", 32'(if_valid), 32'd1);
                    checkOutput("mon_hold_pc", if_pc, prev_pc);
                    checkOutput("mon_hold_inst", if_inst, prev_inst);
                end else if (if_valid) begin
                    checkOutput("mon_deliver_pc", if_pc, exp_pc);
                    checkOutput("mon_deliver_inst", if_inst, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    deliveries++;
                end
                if (!if_valid) checkOutput("mon_bubble_inst", if_inst, NOP);
                if (icache_re) checkOutput("mon_addr_align", 32'(icache_addr[1:0]), 32'd0);
            end
            if (reset) live = 1'b1;
            prev_reset    = reset;
            prev_valid    = if_valid;
            prev_stall_in = stall_in;
            prev_redirect = redirect_valid;
            prev_rpc      = redirect_pc;
            prev_pc       = if_pc;
            prev_inst     = if_inst;
        end
    end

    initial begin
        int start_count;
        logic rst, ist, sin, rv, prev_rst;

        $display("[TB] free-running fetch after reset");
        do_reset();
        free_run(1);
        checkOutput("t1_reset_valid", 32'(if_valid), 32'd0);
        checkOutput("t1_reset_pc", if_pc, 32'd0);
        checkOutput("t1_reset_inst", if_inst, NOP);
        checkOutput("t1_idle_re", 32'(icache_re), 32'd0);
        free_run(1);
        checkOutput("t1_first_re", 32'(icache_re), 32'd1);
        checkOutput("t1_first_addr", icache_addr, 32'h4000_0000);
        free_run(1);
        checkOutput("t1_c2_valid", 32'(if_valid), 32'd0);
        free_run(1);
        checkOutput("t1_rise_valid", 32'(if_valid), 32'd1);
        checkOutput("t1_seq0_pc", if_pc, 32'h4000_0000);
        checkOutput("t1_seq0_inst", if_inst, 32'h5357_9BDF);
        free_run(1);
        checkOutput("t1_seq1_pc", if_pc, 32'h4000_0004);
        free_run(1);
        checkOutput("t1_seq2_pc", if_pc, 32'h4000_0008);
        checkOutput("t1_seq2_valid", 32'(if_valid), 32'd1);

        $display("[TB] memory stall on second fetch");
        do_reset();
        free_run(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_first_pc", if_pc, 32'h4000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_bubble1_valid", 32'(if_valid), 32'd0);
        checkOutput("t2_wait_re", 32'(icache_re), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_bubble2_valid", 32'(if_valid), 32'd0);
        free_run(1);
        checkOutput("t2_bubble3_valid", 32'(if_valid), 32'd0);
        free_run(1);
        checkOutput("t2_second_valid", 32'(if_valid), 32'd1);
        checkOutput("t2_second_pc", if_pc, 32'h4000_0004);
        free_run(1);
        checkOutput("t2_third_pc", if_pc, 32'h4000_0008);

        $display("[TB] decode stall with response arriving");
        do_reset();
        free_run(4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("t3_held_pc_c4", if_pc, 32'h4000_0004);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("t3_hold_re", 32'(icache_re), 32'd0);
        checkOutput("t3_held_pc_c5", if_pc, 32'h4000_0004);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("t3_held_pc_c7", if_pc, 32'h4000_0004);
        checkOutput("t3_held_valid_c7", 32'(if_valid), 32'd1);
        free_run(1);
        free_run(1);
        checkOutput("t3_skid_pc", if_pc, 32'h4000_0008);
        checkOutput("t3_skid_valid", 32'(if_valid), 32'd1);
        checkOutput("t3_resume_addr", icache_addr, 32'h4000_000C);
        free_run(2);
        checkOutput("t3_resume_pc", if_pc, 32'h4000_000C);

        $display("[TB] redirect while response stalled");
        do_reset();
        free_run(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h4000_0103);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t4_flush_re", 32'(icache_re), 32'd0);
        checkOutput("t4_flush_valid", 32'(if_valid), 32'd0);
        free_run(2);
        checkOutput("t4_target_addr", icache_addr, 32'h4000_0100);
        checkOutput("t4_target_re", 32'(icache_re), 32'd1);
        free_run(2);
        checkOutput("t4_target_pc", if_pc, 32'h4000_0100);
        checkOutput("t4_target_inst", if_inst, 32'h642E_2ADF);

        $display("[TB] redirect together with decode stall");
        do_reset();
        free_run(4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h4000_0200);
        free_run(1);
        checkOutput("t5_drop_valid", 32'(if_valid), 32'd0);
        checkOutput("t5_drop_inst", if_inst, 32'h0000_0013);
        free_run(3);
        checkOutput("t5_target_pc", if_pc, 32'h4000_0200);
        checkOutput("t5_target_valid", 32'(if_valid), 32'd1);

        $display("[TB] reset during skid hold");
        do_reset();
        free_run(4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("t6_hold_re", 32'(icache_re), 32'd0);
        free_run(1);
        checkOutput("t6_reset_valid", 32'(if_valid), 32'd0);
        checkOutput("t6_reset_pc", if_pc, 32'd0);
        checkOutput("t6_reset_inst", if_inst, NOP);
        checkOutput("t6_reset_re", 32'(icache_re), 32'd0);
        free_run(3);
        checkOutput("t6_restart_pc", if_pc, 32'h4000_0000);

        $display("[TB] PC wrap after redirect near top of memory");
        do_reset();
        free_run(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        free_run(4);
        checkOutput("t7_pc_f8", if_pc, 32'hFFFF_FFF8);
        free_run(1);
        checkOutput("t7_pc_fc", if_pc, 32'hFFFF_FFFC);
        free_run(1);
        checkOutput("t7_pc_wrap", if_pc, 32'h0000_0000);

        $display("[TB] randomized traffic");
        do_reset();
        start_count = deliveries;
        prev_rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(249) == 0);
            ist = ($urandom_range(3) == 0);
            sin = ($urandom_range(9) < 3);
            rv  = !prev_rst && ($urandom_range(19) == 0);
            applyStimulus(rst, ist, sin, rv, $urandom);
            prev_rst = rst;
        end
        free_run(2);
        checkOutput("rand_progress", 32'((deliveries - start_count) >= 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
